seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 126 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// seven_seg_scanner : 4-digit multiplexed 7-segment scanner with blanking
// Revision 1.0
// ============================================================================
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [3:0] dp_in,
  input  logic [3:0] digit_en,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int unsigned   CW           = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST     = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE_SHOW = CW'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    pat_q, pat_d;
  logic          dp_q, dp_d;
  logic          en_q, en_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic [3:0]    an_n_q, an_n_d;
  logic          tick_q, tick_d;
  logic          wrap;
  logic [6:0]    seg_sel;

  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    tick_d = wrap && (idx_q == 2'd3);

    seg_sel = seg0;
    case (idx_q)
      2'd0: seg_sel = seg0;
      2'd1: seg_sel = seg1;
      2'd2: seg_sel = seg2;
      2'd3: seg_sel = seg3;
      default: seg_sel = seg0;
    endcase

    state_d = state_q;
    pat_d   = pat_q;
    dp_d    = dp_q;
    en_d    = en_q;
    case (state_q)
      ST_BLANK: begin
        // Capture the digit on the same edge that enters SHOW so the
        // displayed value is frozen for the whole visible phase.
        if (cnt_q == CNT_PRE_SHOW) begin
          state_d = ST_SHOW;
          pat_d   = seg_sel;
          dp_d    = dp_in[idx_q];
          en_d    = digit_en[idx_q];
        end
      end
      ST_SHOW: begin
        if (wrap) state_d = ST_BLANK;
      end
      default: state_d = ST_BLANK;
    endcase

    an_n_d  = 4'hF;
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if ((state_q == ST_SHOW) && en_q) begin
      an_n_d  = ~(4'b0001 << idx_q);
      seg_n_d = ~pat_q;
      dp_n_d  = ~dp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      pat_q   <= 7'h00;
      dp_q    <= 1'b0;
      en_q    <= 1'b0;
      seg_n_q <= 7'h7F;
      dp_n_q  <= 1'b1;
      an_n_q  <= 4'hF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      an_n_q  <= an_n_d;
      tick_q  <= tick_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// tb_seven_seg_scanner : scoreboard bench with time-indexed reference model
// Revision 1.0
// ============================================================================
module tb_seven_seg_scanner;

  localparam int R = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic [3:0] dp_in, digit_en;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic [1:0] digit_idx;
  logic       frame_tick;

  seven_seg_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .dp_in(dp_in), .digit_en(digit_en),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Input history indexed by cycle number since reset release
  logic [27:0] hist_seg [8192];
  logic [3:0]  hist_dp  [8192];
  logic [3:0]  hist_en  [8192];
  logic [14:0] exp_q [$];

  int  t        = 0;
  bit  t_valid  = 0;
  int  total    = 0;
  int  bad      = 0;
  int  ticks_exp = 0;
  int  ticks_seen = 0;
  int  mon_cyc  = 0;

  // Expected {an_n, seg_n, dp_n, digit_idx, frame_tick} for cycle tc
  function automatic logic [14:0] model(input int tc);
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic [1:0] ix;
    logic       tk;
    int p, l, d;
    an = 4'hF; sg = 7'h7F; dp = 1'b1;
    ix = 2'((tc / R) % 4);
    tk = (tc > 0) && ((tc % (4 * R)) == 0);
    if (tc >= 1) begin
      p = tc - 1;
      if ((p % R) >= B) begin
        l = (p / R) * R + B - 1;
        d = (p / R) % 4;
        if (hist_en[l][d]) begin
          an = 4'hF & ~(4'b0001 << d);
          sg = ~hist_seg[l][d*7 +: 7];
          dp = ~hist_dp[l][d];
        end
      end
    end
    return {an, sg, dp, ix, tk};
  endfunction

  task automatic step();
    bit          was_rst;
    logic [14:0] e;
    was_rst = !rst_n;
    if (!was_rst && t_valid) begin
      hist_seg[t] = {seg3, seg2, seg1, seg0};
      hist_dp[t]  = dp_in;
      hist_en[t]  = digit_en;
    end
    @(posedge clk);
    if (was_rst) begin
      t = 0;
      t_valid = 1;
      e = {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};
      exp_q.push_back(e);
    end else if (t_valid) begin
      t = t + 1;
      e = model(t);
      exp_q.push_back(e);
    end
    if (t_valid && e[0]) ticks_exp++;
    #1;
  endtask

  task automatic rand_inputs();
    seg0 = 7'($urandom); seg1 = 7'($urandom);
    seg2 = 7'($urandom); seg3 = 7'($urandom);
    dp_in = 4'($urandom);
    digit_en = 4'($urandom);
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle
  initial begin
    logic [14:0] e, a;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {an_n, seg_n, dp_n, digit_idx, frame_tick};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL out cyc=%0d actual an=%b seg=%h dp=%b idx=%0d tick=%b required an=%b seg=%h dp=%b idx=%0d tick=%b",
                   mon_cyc, a[14:11], a[10:4], a[3], a[2:1], a[0],
                   e[14:11], e[10:4], e[3], e[2:1], e[0]);
        end
        if (a[0] === 1'b1) ticks_seen++;
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    seg0 = 7'h3F; seg1 = 7'h06; seg2 = 7'h5B; seg3 = 7'h4F;
    dp_in = 4'h0; digit_en = 4'hF;
    step(); step();
    rst_n = 1'b1;
    repeat (70) step();

    // Digits 1 and 3 disabled, then decimal point only on digit 3
    digit_en = 4'b0101;
    repeat (40) step();
    digit_en = 4'hF; dp_in = 4'b1000;
    repeat (40) step();

    // Update seg1 while digit 1 is being shown
    guard = 0;
    while ((t % (4 * R)) != (R + B + 2) && guard < 100) begin step(); guard++; end
    seg1 = 7'h7F;
    repeat (40) step();

    // One-cycle reset in the middle of slot 2's visible phase
    guard = 0;
    while ((t % (4 * R)) != (2 * R + B + 3) && guard < 100) begin step(); guard++; end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (40) step();

    // Randomised inputs every cycle with occasional short resets
    for (int i = 0; i < 900; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    repeat (40) step();

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin @(negedge clk); guard++; end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
    end
    total++;
    if (ticks_seen != ticks_exp) begin
      bad++;
      $display("FAIL frame_ticks actual=%0d required=%0d", ticks_seen, ticks_exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
